// File: rtl/smc_wr_pkg.sv
// Shared types and constants for the SMC write-strobe sequencer.
//   wr_state_e : sequencer phases (idle, address setup, strobe, hold)
//   CNT_W_DEF  : default width of each phase-count field
//   BE_W_DEF   : default number of byte lanes
//   N_WE_IDLE  : inactive per-lane write enable (all lanes deasserted)
//   N_WR_IDLE  : inactive write strobe level
package smc_wr_pkg;

  localparam int unsigned CNT_W_DEF = 4;
  localparam int unsigned BE_W_DEF  = 4;

  typedef enum logic [1:0] {
    StIdle,
    StSetup,
    StStrobe,
    StHold
  } wr_state_e;

  localparam logic [BE_W_DEF-1:0] N_WE_IDLE = '1;
  localparam logic                N_WR_IDLE = 1'b1;

endpackage

// File: rtl/smc_wr_timer.sv
// Loadable phase down-counter for the write sequencer.
//   clk_i       : clock
//   rst_i       : asynchronous active-high reset, count returns to 0
//   load_i      : load value_i at the next edge (wins over counting)
//   value_i     : count to load (phase length minus one)
//   zero_o      : current count is 0 (last cycle of the phase)
//   zero_next_o : count will be 0 after the next edge
// The counter decrements toward 0 and then sits at 0; it never wraps.
module smc_wr_timer #(
  parameter int unsigned CNT_W = 4
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             load_i,
  input  logic [CNT_W-1:0] value_i,
  output logic             zero_o,
  output logic             zero_next_o
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = value_i;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero_o      = (cnt_q == '0);
  assign zero_next_o = (cnt_d == '0);

endmodule

// File: rtl/smc_wr_strobe_ctrl.sv
// Write-cycle sequencer for the static memory controller.
// Steps one write request through setup, strobe and hold phases and drives the
// registered strobe controls consumed by the write-enable gating stage.
//   hclk       : clock
//   sys_reset  : asynchronous active-high reset
//   wr_req     : write request, held until wr_ack
//   wr_be      : byte enables of the request (1 = lane written)
//   cfg_setup  : setup cycles (0 allowed)
//   cfg_strobe : strobe cycles (0 treated as 1)
//   cfg_hold   : hold cycles (0 allowed)
//   r_full     : high only during strobe
//   n_r_we     : per-lane write enable, active low, asserted only during strobe
//   n_r_wr     : write strobe, active low
//   wr_busy    : access in progress
//   wr_ack     : one-cycle pulse in the final cycle of an access
module smc_wr_strobe_ctrl
  import smc_wr_pkg::*;
#(
  parameter int unsigned CNT_W = CNT_W_DEF,
  parameter int unsigned BE_W  = BE_W_DEF
) (
  input  logic             hclk,
  input  logic             sys_reset,
  input  logic             wr_req,
  input  logic [BE_W-1:0]  wr_be,
  input  logic [CNT_W-1:0] cfg_setup,
  input  logic [CNT_W-1:0] cfg_strobe,
  input  logic [CNT_W-1:0] cfg_hold,
  output logic             r_full,
  output logic [BE_W-1:0]  n_r_we,
  output logic             n_r_wr,
  output logic             wr_busy,
  output logic             wr_ack
);

  wr_state_e        state_q, state_d;
  logic [BE_W-1:0]  be_q, be_d;
  logic [CNT_W-1:0] strobe_q, strobe_d;
  logic [CNT_W-1:0] hold_q, hold_d;

  logic             tmr_load;
  logic [CNT_W-1:0] tmr_value;
  logic             tmr_zero;
  logic             tmr_zero_next;

  logic             r_full_q, r_full_d;
  logic [BE_W-1:0]  n_r_we_q, n_r_we_d;
  logic             n_r_wr_q, n_r_wr_d;
  logic             wr_busy_q, wr_busy_d;
  logic             wr_ack_q, wr_ack_d;

  // Strobe length is at least one cycle; the counter is loaded with length - 1.
  function automatic logic [CNT_W-1:0] strobe_first(input logic [CNT_W-1:0] cnt);
    return (cnt == '0) ? '0 : cnt - CNT_W'(1);
  endfunction

  smc_wr_timer #(
    .CNT_W (CNT_W)
  ) u_timer (
    .clk_i       (hclk),
    .rst_i       (sys_reset),
    .load_i      (tmr_load),
    .value_i     (tmr_value),
    .zero_o      (tmr_zero),
    .zero_next_o (tmr_zero_next)
  );

  // State and request latch.
  always_ff @(posedge hclk or posedge sys_reset) begin
    if (sys_reset) begin
      state_q  <= StIdle;
      be_q     <= '0;
      strobe_q <= '0;
      hold_q   <= '0;
    end else begin
      state_q  <= state_d;
      be_q     <= be_d;
      strobe_q <= strobe_d;
      hold_q   <= hold_d;
    end
  end

  // Next state, request capture and phase counter loads.
  always_comb begin
    state_d   = state_q;
    be_d      = be_q;
    strobe_d  = strobe_q;
    hold_d    = hold_q;
    tmr_load  = 1'b0;
    tmr_value = '0;
    unique case (state_q)
      StIdle: begin
        if (wr_req) begin
          be_d     = wr_be;
          strobe_d = cfg_strobe;
          hold_d   = cfg_hold;
          tmr_load = 1'b1;
          if (cfg_setup != '0) begin
            state_d   = StSetup;
            tmr_value = cfg_setup - CNT_W'(1);
          end else begin
            state_d   = StStrobe;
            tmr_value = strobe_first(cfg_strobe);
          end
        end
      end
      StSetup: begin
        if (tmr_zero) begin
          state_d   = StStrobe;
          tmr_load  = 1'b1;
          tmr_value = strobe_first(strobe_q);
        end
      end
      StStrobe: begin
        if (tmr_zero) begin
          if (hold_q != '0) begin
            state_d   = StHold;
            tmr_load  = 1'b1;
            tmr_value = hold_q - CNT_W'(1);
          end else begin
            state_d = StIdle;
          end
        end
      end
      StHold: begin
        if (tmr_zero) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Outputs are registered, so they are derived from the state being entered.
  // The ack lands in the last cycle of the final phase: hold, or strobe when
  // the captured hold count is zero.
  always_comb begin
    r_full_d  = (state_d == StStrobe);
    n_r_wr_d  = (state_d == StStrobe) ? ~N_WR_IDLE : N_WR_IDLE;
    n_r_we_d  = (state_d == StStrobe) ? ~be_d : {BE_W{N_WR_IDLE}};
    wr_busy_d = (state_d != StIdle);
    wr_ack_d  = tmr_zero_next &&
                ((state_d == StHold) || ((state_d == StStrobe) && (hold_d == '0)));
  end

  always_ff @(posedge hclk or posedge sys_reset) begin
    if (sys_reset) begin
      r_full_q  <= 1'b0;
      n_r_we_q  <= {BE_W{N_WR_IDLE}};
      n_r_wr_q  <= N_WR_IDLE;
      wr_busy_q <= 1'b0;
      wr_ack_q  <= 1'b0;
    end else begin
      r_full_q  <= r_full_d;
      n_r_we_q  <= n_r_we_d;
      n_r_wr_q  <= n_r_wr_d;
      wr_busy_q <= wr_busy_d;
      wr_ack_q  <= wr_ack_d;
    end
  end

  assign r_full  = r_full_q;
  assign n_r_we  = n_r_we_q;
  assign n_r_wr  = n_r_wr_q;
  assign wr_busy = wr_busy_q;
  assign wr_ack  = wr_ack_q;

endmodule

// File: tb/tb_smc_wr_strobe_ctrl.sv
// Bench for smc_wr_strobe_ctrl. Per-cycle expected output vectors
// {r_full, n_r_we, n_r_wr, wr_busy, wr_ack} are derived from the access
// timing (S setup, W strobe, H hold cycles) and queued when a request is driven;
// a negedge monitor pops and compares one vector per cycle.
module tb_smc_wr_strobe_ctrl;

  localparam int unsigned CW = 4;
  localparam int unsigned BW = 4;

  typedef struct {
    logic [7:0] v;
    string      tag;
  } exp_t;

  logic          hclk;
  logic          sys_reset;
  logic          wr_req;
  logic [BW-1:0] wr_be;
  logic [CW-1:0] cfg_setup;
  logic [CW-1:0] cfg_strobe;
  logic [CW-1:0] cfg_hold;
  logic          r_full;
  logic [BW-1:0] n_r_we;
  logic          n_r_wr;
  logic          wr_busy;
  logic          wr_ack;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   acc_id   = 0;

  smc_wr_strobe_ctrl #(
    .CNT_W (CW),
    .BE_W  (BW)
  ) dut (
    .hclk       (hclk),
    .sys_reset  (sys_reset),
    .wr_req     (wr_req),
    .wr_be      (wr_be),
    .cfg_setup  (cfg_setup),
    .cfg_strobe (cfg_strobe),
    .cfg_hold   (cfg_hold),
    .r_full     (r_full),
    .n_r_we     (n_r_we),
    .n_r_wr     (n_r_wr),
    .wr_busy    (wr_busy),
    .wr_ack     (wr_ack)
  );

  initial hclk = 1'b0;
  always #5 hclk = ~hclk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] outs();
    return {r_full, n_r_we, n_r_wr, wr_busy, wr_ack};
  endfunction

  // ph: 0 idle, 1 setup, 2 strobe, 3 hold
  function automatic logic [7:0] vec(input int ph, input logic [3:0] be, input logic ack);
    case (ph)
      1:       return {1'b0, 4'hF, 1'b1, 1'b1, 1'b0};
      2:       return {1'b1, ~be, 1'b0, 1'b1, ack};
      3:       return {1'b0, 4'hF, 1'b1, 1'b1, ack};
      default: return {1'b0, 4'hF, 1'b1, 1'b0, 1'b0};
    endcase
  endfunction

  task automatic push(input logic [7:0] v, input string tag);
    exp_t e;
    e.v   = v;
    e.tag = tag;
    exp_q.push_back(e);
  endtask

  // Queues cycles 1..S+W+H of one access; returns its length.
  task automatic push_access(input int s, input int w, input int h, input logic [3:0] be,
                             output int len);
    int weff;
    weff = (w == 0) ? 1 : w;
    acc_id++;
    for (int i = 0; i < s; i++) push(vec(1, be, 1'b0), $sformatf("a%0d setup%0d", acc_id, i));
    for (int i = 0; i < weff; i++)
      push(vec(2, be, (h == 0) && (i == weff - 1)), $sformatf("a%0d strobe%0d", acc_id, i));
    for (int i = 0; i < h; i++)
      push(vec(3, be, i == h - 1), $sformatf("a%0d hold%0d", acc_id, i));
    len = s + weff + h;
  endtask

  // One isolated access; config and byte enables are scrambled right after
  // acceptance, which must not affect the access in flight.
  task automatic run_access(input int s, input int w, input int h, input logic [3:0] be);
    int len;
    @(posedge hclk);
    #2;
    cfg_setup  = CW'(s);
    cfg_strobe = CW'(w);
    cfg_hold   = CW'(h);
    wr_be      = be;
    wr_req     = 1'b1;
    push(vec(0, be, 1'b0), $sformatf("a%0d pre-idle", acc_id + 1));
    push_access(s, w, h, be, len);
    @(posedge hclk);
    #2;
    wr_req     = 1'b0;
    cfg_strobe = 4'd7;
    cfg_setup  = CW'($urandom_range(15));
    cfg_hold   = CW'($urandom_range(15));
    wr_be      = BW'($urandom);
    repeat (len) @(posedge hclk);
    #2;
  endtask

  always @(negedge hclk) begin
    exp_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check(e.tag, {24'd0, outs()}, {24'd0, e.v});
    end
  end

  initial begin
    int len;
    sys_reset  = 1'b1;
    wr_req     = 1'b0;
    wr_be      = '0;
    cfg_setup  = '0;
    cfg_strobe = '0;
    cfg_hold   = '0;
    #3;
    check("reset outputs", {24'd0, outs()}, {24'd0, vec(0, 4'h0, 1'b0)});
    repeat (2) @(posedge hclk);
    #2;
    sys_reset = 1'b0;

    run_access(2, 3, 1, 4'b0101);
    run_access(0, 0, 0, 4'b1111);
    run_access(2, 2, 1, 4'b0011);   // cfg_strobe becomes 7 during setup
    run_access(0, 2, 0, 4'b0000);
    run_access(15, 15, 15, 4'b1001);
    run_access(3, 1, 0, 4'b1000);
    run_access(0, 5, 2, 4'b0110);

    // Request held high: ack in cycles 3, 7, 11, idle in 4, 8, 12.
    @(posedge hclk);
    #2;
    cfg_setup  = 4'd1;
    cfg_strobe = 4'd1;
    cfg_hold   = 4'd1;
    wr_be      = 4'b1010;
    wr_req     = 1'b1;
    push(vec(0, 4'h0, 1'b0), "b2b idle0");
    for (int k = 0; k < 3; k++) begin
      push_access(1, 1, 1, 4'b1010, len);
      push(vec(0, 4'h0, 1'b0), $sformatf("b2b idle%0d", k + 1));
    end
    repeat (12) @(posedge hclk);
    #2;
    wr_req = 1'b0;
    repeat (3) @(posedge hclk);

    // Reset in the second strobe cycle (cycle 3 with S=1, W=3, H=2).
    #2;
    cfg_setup  = 4'd1;
    cfg_strobe = 4'd3;
    cfg_hold   = 4'd2;
    wr_be      = 4'b1100;
    wr_req     = 1'b1;
    acc_id++;
    push(vec(0, 4'h0, 1'b0), "rst pre-idle");
    push(vec(1, 4'b1100, 1'b0), "rst setup0");
    push(vec(2, 4'b1100, 1'b0), "rst strobe0");
    @(posedge hclk);
    #2;
    wr_req = 1'b0;
    repeat (2) @(posedge hclk);
    #1;
    check("rst strobe1 pre", {24'd0, outs()}, {24'd0, vec(2, 4'b1100, 1'b0)});
    #1;
    sys_reset = 1'b1;
    #1;
    check("rst async outputs", {24'd0, outs()}, {24'd0, vec(0, 4'h0, 1'b0)});
    #1;
    sys_reset = 1'b0;
    repeat (6) begin
      @(negedge hclk);
      check("rst no ack", {24'd0, outs()}, {24'd0, vec(0, 4'h0, 1'b0)});
    end
    run_access(1, 3, 2, 4'b1100);

    for (int i = 0; i < 200 && exp_q.size() > 0; i++) @(posedge hclk);
    @(posedge hclk);
    check("queue drained", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
